// File: rtl/alu_writeback_sequencer.sv
// Four-state ALU sequencer: IDLE -> READ -> EXEC -> WB, one instruction per 4 cycles.
// Optional flag registers (Zero/Carry) are built only when ALU_WRITEBACK_FLAGS_EN is defined.
module alu_writeback_sequencer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Instr_Valid,
    output logic         Instr_Ready,
    input  logic [2:0]   Op,
    input  logic [2:0]   Src0,
    input  logic [2:0]   Src1,
    input  logic [2:0]   Dst,
    output logic [2:0]   Source_Select_0,
    output logic [2:0]   Source_Select_1,
    input  logic [W-1:0] Out_0,
    input  logic [W-1:0] Out_1,
    output logic [W-1:0] Data,
    output logic [2:0]   Destination_Select,
    output logic         Write_Enable,
    output logic         Done,
    output logic         Zero,
    output logic         Carry
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t       state, state_nxt;
    logic [2:0]   op_q, src0_q, src1_q, dst_q;
    logic [W-1:0] opa_q, opb_q, res_q, alu_res;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (Instr_Valid) state_nxt = READ;
            READ: state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op_q)
            3'b000: alu_res = opa_q + opb_q;
            3'b001: alu_res = opa_q - opb_q;
            3'b010: alu_res = opa_q & opb_q;
            3'b011: alu_res = opa_q | opb_q;
            3'b100: alu_res = opa_q ^ opb_q;
            3'b101: alu_res = ~opa_q;
            3'b110: alu_res = opa_q;
            3'b111: alu_res = opa_q << 1;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            op_q   <= '0;
            src0_q <= '0;
            src1_q <= '0;
            dst_q  <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            res_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && Instr_Valid) begin
                op_q   <= Op;
                src0_q <= Src0;
                src1_q <= Src1;
                dst_q  <= Dst;
            end
            // Register file read path is combinational; sample it at the end of READ.
            if (state == READ) begin
                opa_q <= Out_0;
                opb_q <= Out_1;
            end
            if (state == EXEC) res_q <= alu_res;
        end
    end

    // Reset forces IDLE asynchronously, so only Instr_Ready needs explicit gating.
    assign Instr_Ready        = (state == IDLE) && !Reset;
    assign Source_Select_0    = (state == READ || state == EXEC) ? src0_q : 3'd0;
    assign Source_Select_1    = (state == READ || state == EXEC) ? src1_q : 3'd0;
    assign Write_Enable       = (state == WB);
    assign Done               = (state == WB);
    assign Destination_Select = (state == WB) ? dst_q : 3'd0;
    assign Data               = (state == WB) ? res_q : '0;

`ifdef ALU_WRITEBACK_FLAGS_EN
    logic alu_carry, carry_q, zero_q, res_carry_q;

    // Truncated sum below A means the add wrapped.
    always_comb begin
        alu_carry = 1'b0;
        case (op_q)
            3'b000:  alu_carry = (alu_res < opa_q);
            3'b001:  alu_carry = (opa_q < opb_q);
            3'b111:  alu_carry = opa_q[W-1];
            default: alu_carry = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            res_carry_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            if (state == EXEC) res_carry_q <= alu_carry;
            if (state == WB) begin
                zero_q  <= (res_q == '0);
                carry_q <= res_carry_q;
            end
        end
    end

    assign Zero  = zero_q;
    assign Carry = carry_q;
`else
    assign Zero  = 1'b0;
    assign Carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// Directed bench for alu_writeback_sequencer with a model register file,
// a cycle-level state model and a write-back scoreboard.
module tb_alu_writeback_sequencer;
    localparam int W = 4;
`ifdef ALU_WRITEBACK_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]   dst;
        logic         c;
        logic [W-1:0] d;
    } wb_t;

    logic         CLK = 1'b0;
    logic         Reset = 1'b1;
    logic         Instr_Valid = 1'b0;
    logic         Instr_Ready;
    logic [2:0]   Op = '0, Src0 = '0, Src1 = '0, Dst = '0;
    logic [2:0]   Source_Select_0, Source_Select_1, Destination_Select;
    logic [W-1:0] Out_0, Out_1, Data;
    logic         Write_Enable, Done, Zero, Carry;

    logic [W-1:0] rf [8];
    logic         poke_en = 1'b0;
    logic [2:0]   poke_a = '0;
    logic [W-1:0] poke_d = '0;

    int checks = 0, errors = 0, dones = 0, accepts = 0;
    int st = 0;
    logic [2:0] ls0 = '0, ls1 = '0, ldst = '0, lop = '0;
    logic ez = 1'b0, ec = 1'b0;
    wb_t sb[$];
    wb_t ent;
    logic [W-1:0] old7;
    int acc0, done0;

    alu_writeback_sequencer #(.W(W)) dut (
        .CLK(CLK), .Reset(Reset), .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
        .Op(Op), .Src0(Src0), .Src1(Src1), .Dst(Dst),
        .Source_Select_0(Source_Select_0), .Source_Select_1(Source_Select_1),
        .Out_0(Out_0), .Out_1(Out_1), .Data(Data), .Destination_Select(Destination_Select),
        .Write_Enable(Write_Enable), .Done(Done), .Zero(Zero), .Carry(Carry)
    );

    always #5 CLK = ~CLK;

    assign Out_0 = rf[Source_Select_0];
    assign Out_1 = rf[Source_Select_1];

    always @(posedge CLK) begin
        if (poke_en) rf[poke_a] <= poke_d;
        else if (Write_Enable) rf[Destination_Select] <= Data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        case (op)
            3'd0: s = {1'b0, a} + {1'b0, b};
            3'd1: s = {(a < b), a - b};
            3'd2: s = {1'b0, a & b};
            3'd3: s = {1'b0, a | b};
            3'd4: s = {1'b0, a ^ b};
            3'd5: s = {1'b0, ~a};
            3'd6: s = {1'b0, a};
            default: s = {a[W-1], a[W-2:0], 1'b0};
        endcase
        return s;
    endfunction

    // Cycle model: state, latched fields, scoreboard push at READ, pop at WB.
    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            st = 0; ez = 1'b0; ec = 1'b0;
            sb.delete();
        end else begin
            case (st)
                0: if (Instr_Valid) begin
                    lop = Op; ls0 = Src0; ls1 = Src1; ldst = Dst;
                    accepts++; st = 1;
                end
                1: begin
                    logic [W:0] r;
                    r = alu(lop, rf[ls0], rf[ls1]);
                    sb.push_back('{dst: ldst, c: r[W], d: r[W-1:0]});
                    st = 2;
                end
                2: st = 3;
                default: begin
                    if (sb.size() > 0) begin
                        ent = sb.pop_front();
                        ez = (ent.d == '0); ec = ent.c;
                    end
                    st = 0;
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        chk("ready", Instr_Ready, (st == 0 && !Reset));
        chk("sel0", Source_Select_0, (st == 1 || st == 2) ? ls0 : 3'd0);
        chk("sel1", Source_Select_1, (st == 1 || st == 2) ? ls1 : 3'd0);
        chk("we", Write_Enable, st == 3);
        chk("done", Done, st == 3);
        chk("zero", Zero, FLAGS ? ez : 1'b0);
        chk("carry", Carry, FLAGS ? ec : 1'b0);
        if (st == 3) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                chk("wb_dst", Destination_Select, sb[0].dst);
                chk("wb_data", Data, sb[0].d);
            end
        end else begin
            chk("dst_idle", Destination_Select, 0);
            chk("data_idle", Data, 0);
        end
        if (Done === 1'b1) dones++;
    end

    task automatic poke(input logic [2:0] a, input logic [W-1:0] d);
        poke_a = a; poke_d = d; poke_en = 1'b1;
        @(posedge CLK); #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] d);
        Op = op; Src0 = s0; Src1 = s1; Dst = d; Instr_Valid = 1'b1;
        @(posedge CLK); #1;
        Instr_Valid = 1'b0;
        repeat (4) begin @(posedge CLK); #1; end
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ready", Instr_Ready, 0);
        chk("rst_we", Write_Enable, 0);
        chk("rst_data", Data, 0);
        chk("rst_zero", Zero, 0);
        @(posedge CLK); #1;
        Reset = 1'b0;

        // ADD 7+9 -> 0, carry out; explicit latency walk.
        poke(3'd1, 4'd7);
        poke(3'd2, 4'd9);
        Op = 3'd0; Src0 = 3'd1; Src1 = 3'd2; Dst = 3'd3; Instr_Valid = 1'b1;
        @(posedge CLK); #1;
        Instr_Valid = 1'b0;
        @(negedge CLK); chk("lat_read_we", Write_Enable, 0);
        @(negedge CLK); chk("lat_exec_we", Write_Enable, 0);
        @(negedge CLK);
        chk("add_we", Write_Enable, 1);
        chk("add_data", Data, 0);
        chk("add_dst", Destination_Select, 3);
        chk("add_done", Done, 1);
        @(posedge CLK); #1;
        chk("add_zero", Zero, FLAGS);
        chk("add_carry", Carry, FLAGS);
        chk("add_we_off", Write_Enable, 0);

        // SUB 2-5 -> 13 with borrow.
        poke(3'd4, 4'd2);
        poke(3'd5, 4'd5);
        issue(3'd1, 3'd4, 3'd5, 3'd6);
        chk("sub_rf", rf[6], 13);
        chk("sub_zero", Zero, 0);
        chk("sub_carry", Carry, FLAGS);

        issue(3'd3, 3'd1, 3'd2, 3'd7);
        issue(3'd5, 3'd4, 3'd0, 3'd0);
        issue(3'd7, 3'd2, 3'd0, 3'd4);
        chk("shl_rf", rf[4], 2);

        // Valid held high across three instructions; third reads second's write.
        acc0 = accepts; done0 = dones;
        Instr_Valid = 1'b1;
        Op = 3'd2; Src0 = 3'd1; Src1 = 3'd2; Dst = 3'd5;
        repeat (4) begin @(posedge CLK); #1; end
        Op = 3'd4; Src0 = 3'd5; Src1 = 3'd6; Dst = 3'd5;
        repeat (4) begin @(posedge CLK); #1; end
        Op = 3'd0; Src0 = 3'd5; Src1 = 3'd5; Dst = 3'd7;
        repeat (4) begin @(posedge CLK); #1; end
        Instr_Valid = 1'b0;
        chk("held_accepts", accepts - acc0, 3);
        chk("held_dones", dones - done0, 3);
        chk("held_rf", rf[7], 8);
        repeat (2) begin @(posedge CLK); #1; end

        // Reset during EXEC aborts the write.
        old7 = rf[7];
        Op = 3'd0; Src0 = 3'd1; Src1 = 3'd2; Dst = 3'd7; Instr_Valid = 1'b1;
        @(posedge CLK); #1;
        Instr_Valid = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(negedge CLK);
        chk("rst_mid_we", Write_Enable, 0);
        chk("rst_mid_ready", Instr_Ready, 0);
        chk("rst_mid_sel", Source_Select_0, 0);
        chk("rst_mid_data", Data, 0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        @(negedge CLK);
        chk("post_rst_ready", Instr_Ready, 1);
        repeat (4) begin @(posedge CLK); #1; end
        chk("rst_no_write", rf[7], old7);

        // MOV r2<-r2 then ADD r2+r1 uses the post-write value.
        poke(3'd2, 4'd4);
        poke(3'd1, 4'd1);
        issue(3'd6, 3'd2, 3'd0, 3'd2);
        issue(3'd0, 3'd2, 3'd1, 3'd2);
        chk("mov_add_rf", rf[2], 5);

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
